// File: rtl/diram_phy_responder_pkg.sv
// Shared definitions for the DIRAM PHY responder: command codes and default geometry/timing.
package diram_phy_responder_pkg;

  localparam int unsigned DEF_NUM_WORDS = 2;
  localparam int unsigned DEF_WORD_W    = 32;
  localparam int unsigned DEF_BANK_W    = 2;
  localparam int unsigned DEF_ADDR_W    = 12;
  localparam int unsigned DEF_IDX_W     = 4;
  localparam int unsigned DEF_RD_LAT    = 4;
  localparam int unsigned DEF_TRC       = 3;
  localparam int unsigned DEF_REF_CYC   = 8;

  // {cmd1, cmd0}
  typedef enum logic [1:0] {
    CmdNop     = 2'b00,
    CmdRead    = 2'b01,
    CmdWrite   = 2'b10,
    CmdRefresh = 2'b11
  } dfi_cmd_e;

  // Counter width able to hold the larger of the two busy reload values.
  function automatic int unsigned timer_width(input int unsigned trc, input int unsigned ref_cyc);
    int unsigned max_val;
    max_val = (ref_cyc > trc) ? ref_cyc : trc;
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/diram_bank_timer.sv
// Down-counting busy timer: loading a value N keeps busy high for the next N cycles.
module diram_bank_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_poweron,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Reload on an accepted command, otherwise count down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy = (cnt_q != '0);

endmodule

// File: rtl/diram_phy_responder.sv
// DIRAM PHY responder: banked storage with fixed-latency reads, per-bank and refresh busy
// timing, and a saturating count of commands dropped because their target was busy.
module diram_phy_responder
  import diram_phy_responder_pkg::*;
#(
  parameter int unsigned NUM_WORDS = DEF_NUM_WORDS,
  parameter int unsigned WORD_W    = DEF_WORD_W,
  parameter int unsigned BANK_W    = DEF_BANK_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned IDX_W     = DEF_IDX_W,
  parameter int unsigned RD_LAT    = DEF_RD_LAT,
  parameter int unsigned TRC       = DEF_TRC,
  parameter int unsigned REF_CYC   = DEF_REF_CYC
) (
  input  logic                        clk,
  input  logic                        reset_poweron,
  input  logic                        dfi__phy__cs,
  input  logic                        dfi__phy__cmd1,
  input  logic                        dfi__phy__cmd0,
  input  logic [BANK_W-1:0]           dfi__phy__bank,
  input  logic [ADDR_W-1:0]           dfi__phy__addr,
  input  logic [NUM_WORDS*WORD_W-1:0] dfi__phy__data,
  output logic                        phy__dfi__valid,
  output logic [NUM_WORDS*WORD_W-1:0] phy__dfi__data,
  output logic                        phy__dfi__chan,
  output logic [15:0]                 phy__dfi__viol_cnt
);

  localparam int unsigned DATA_W    = NUM_WORDS * WORD_W;
  localparam int unsigned NUM_BANKS = 2 ** BANK_W;
  localparam int unsigned DEPTH     = 2 ** (BANK_W + IDX_W);
  localparam int unsigned CNT_W     = timer_width(TRC, REF_CYC);

  // Bank busy covers t+1..t+TRC-1; refresh busy covers t+1..t+REF_CYC.
  localparam logic [CNT_W-1:0] BANK_LOAD = CNT_W'(TRC - 1);
  localparam logic [CNT_W-1:0] REF_LOAD  = CNT_W'(REF_CYC);

  dfi_cmd_e                    cmd;
  logic [BANK_W+IDX_W-1:0]     idx;
  logic [NUM_BANKS-1:0]        bank_busy, bank_load;
  logic                        ref_busy, ref_load;
  logic                        tgt_busy, any_busy;
  logic                        rd_acc, wr_acc, drop;
  logic [DATA_W-1:0]           rd_data;
  logic                        phase_q;
  logic [15:0]                 viol_q, viol_d;
  logic [RD_LAT-1:0]           pipe_vld_q, pipe_chan_q;
  logic [DATA_W-1:0]           pipe_dat_q [RD_LAT];
  logic [DATA_W-1:0]           mem [DEPTH];

  // Upper address bits do not select storage.
  logic unused_addr;
  assign unused_addr = ^dfi__phy__addr;

  // Decode the command and decide whether it is accepted or dropped.
  always_comb begin
    cmd      = dfi_cmd_e'({dfi__phy__cmd1, dfi__phy__cmd0});
    idx      = {dfi__phy__bank, dfi__phy__addr[IDX_W-1:0]};
    tgt_busy = bank_busy[dfi__phy__bank] | ref_busy;
    any_busy = (|bank_busy) | ref_busy;
    rd_data  = mem[idx];
    rd_acc   = 1'b0;
    wr_acc   = 1'b0;
    ref_load = 1'b0;
    drop     = 1'b0;
    // Gating with reset keeps storage untouched while reset is held.
    if (dfi__phy__cs && reset_poweron) begin
      unique case (cmd)
        CmdRead:    if (tgt_busy) drop = 1'b1; else rd_acc = 1'b1;
        CmdWrite:   if (tgt_busy) drop = 1'b1; else wr_acc = 1'b1;
        CmdRefresh: if (any_busy) drop = 1'b1; else ref_load = 1'b1;
        CmdNop:     ;
        default:    ;
      endcase
    end
  end

  // Only the addressed bank's timer reloads on an accepted read or write.
  always_comb begin
    bank_load = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_load[b] = (rd_acc | wr_acc) && (dfi__phy__bank == BANK_W'(b));
    end
  end

  // Saturating drop counter next state.
  always_comb begin
    viol_d = viol_q;
    if (drop && (viol_q != 16'hFFFF)) begin
      viol_d = viol_q + 16'd1;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    diram_bank_timer #(
      .CNT_W(CNT_W)
    ) u_timer (
      .clk          (clk),
      .reset_poweron(reset_poweron),
      .load         (bank_load[b]),
      .load_val     (BANK_LOAD),
      .busy         (bank_busy[b])
    );
  end

  diram_bank_timer #(
    .CNT_W(CNT_W)
  ) u_ref_timer (
    .clk          (clk),
    .reset_poweron(reset_poweron),
    .load         (ref_load),
    .load_val     (REF_LOAD),
    .busy         (ref_busy)
  );

  // Storage is not reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[idx] <= dfi__phy__data;
    end
  end

  // Phase, drop counter and the read-return shift register.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      phase_q     <= 1'b0;
      viol_q      <= '0;
      pipe_vld_q  <= '0;
      pipe_chan_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_dat_q[i] <= '0;
      end
    end else begin
      phase_q        <= ~phase_q;
      viol_q         <= viol_d;
      // Idle slots carry zeros so the outputs are clean whenever valid is low.
      pipe_vld_q[0]  <= rd_acc;
      pipe_chan_q[0] <= rd_acc & phase_q;
      pipe_dat_q[0]  <= rd_acc ? rd_data : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_chan_q[i] <= pipe_chan_q[i-1];
        pipe_dat_q[i]  <= pipe_dat_q[i-1];
      end
    end
  end

  assign phy__dfi__valid    = pipe_vld_q[RD_LAT-1];
  assign phy__dfi__chan     = pipe_chan_q[RD_LAT-1];
  assign phy__dfi__data     = pipe_dat_q[RD_LAT-1];
  assign phy__dfi__viol_cnt = viol_q;

endmodule

// File: tb/tb_diram_phy_responder.sv
// Randomized bench for diram_phy_responder with a cycle-level reference model.
module tb_diram_phy_responder;

  localparam int RD_LAT  = 4;
  localparam int TRC     = 3;
  localparam int REF_CYC = 8;

  logic        clk = 1'b0;
  logic        reset_poweron = 1'b0;
  logic        cs = 1'b0, cmd1 = 1'b0, cmd0 = 1'b0;
  logic [1:0]  bank = '0;
  logic [11:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        valid, chan;
  logic [63:0] rdata;
  logic [15:0] viol;

  int total = 0;
  int bad   = 0;

  diram_phy_responder dut (
    .clk               (clk),
    .reset_poweron     (reset_poweron),
    .dfi__phy__cs      (cs),
    .dfi__phy__cmd1    (cmd1),
    .dfi__phy__cmd0    (cmd0),
    .dfi__phy__bank    (bank),
    .dfi__phy__addr    (addr),
    .dfi__phy__data    (wdata),
    .phy__dfi__valid   (valid),
    .phy__dfi__data    (rdata),
    .phy__dfi__chan    (chan),
    .phy__dfi__viol_cnt(viol)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {int due; logic [63:0] data; logic chan;} rsp_t;
  typedef struct {int cyc; logic [63:0] data; logic chan;} obs_t;

  rsp_t        pend[$];
  obs_t        obs[$];
  logic [63:0] mem_m [int];
  int          bank_until [4];
  int          ref_until = -1;
  int          viol_m = 0;
  int          cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [63:0] pf(input int i);
    return {32'h1000_0000 + 32'(i), 32'hC000_0000 ^ 32'(i)};
  endfunction

  // Model: evaluate the command of the cycle ending at this edge.
  always @(posedge clk) begin
    if (!reset_poweron) begin
      pend.delete();
      for (int b = 0; b < 4; b++) bank_until[b] = -1;
      ref_until = -1;
      viol_m    = 0;
      cyc       = 0;
    end else begin
      if (cs && {cmd1, cmd0} != 2'b00) begin
        int b;
        int ix;
        bit busy;
        b  = int'(bank);
        ix = b * 16 + int'(addr[3:0]);
        if ({cmd1, cmd0} == 2'b11) begin
          busy = (cyc <= ref_until);
          for (int k = 0; k < 4; k++) if (cyc <= bank_until[k]) busy = 1;
        end else begin
          busy = (cyc <= bank_until[b]) || (cyc <= ref_until);
        end
        if (busy) begin
          if (viol_m != 32'hFFFF) viol_m++;
        end else if ({cmd1, cmd0} == 2'b11) begin
          ref_until = cyc + REF_CYC;
        end else begin
          bank_until[b] = cyc + TRC - 1;
          if ({cmd1, cmd0} == 2'b10) begin
            mem_m[ix] = wdata;
          end else begin
            rsp_t r;
            r.due  = cyc + RD_LAT;
            r.data = mem_m.exists(ix) ? mem_m[ix] : 64'hx;
            r.chan = cyc[0];
            pend.push_back(r);
          end
        end
      end
      cyc++;
    end
  end

  // Compare DUT against the model every cycle, mid-cycle.
  always @(negedge clk) begin
    if (!reset_poweron) begin
      chk("rst_valid", {63'd0, valid}, 64'd0);
      chk("rst_data", rdata, 64'd0);
      chk("rst_chan", {63'd0, chan}, 64'd0);
      chk("rst_viol", {48'd0, viol}, 64'd0);
    end else begin
      bit exp_v;
      exp_v = (pend.size() > 0) && (pend[0].due == cyc);
      chk("valid", {63'd0, valid}, {63'd0, exp_v});
      if (exp_v) begin
        if (!$isunknown(pend[0].data)) chk("data", rdata, pend[0].data);
        chk("chan", {63'd0, chan}, {63'd0, pend[0].chan});
        void'(pend.pop_front());
      end else begin
        chk("idle_data", rdata, 64'd0);
        chk("idle_chan", {63'd0, chan}, 64'd0);
      end
      chk("viol", {48'd0, viol}, 64'(viol_m));
      if (valid) begin
        obs_t o;
        o.cyc  = cyc;
        o.data = rdata;
        o.chan = chan;
        obs.push_back(o);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic c, input logic [1:0] code, input int b, input int a,
                       input logic [63:0] d);
    cs = c;
    {cmd1, cmd0} = code;
    bank = 2'(b);
    addr = 12'(a);
    wdata = d;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 2'b00, 0, 0, 64'd0);
  endtask

  initial begin
    int n, k, v0;
    repeat (3) @(posedge clk);
    #2 reset_poweron = 1'b1;
    @(negedge clk);
    chk("post_rst_viol", {48'd0, viol}, 64'd0);
    chk("post_rst_valid", {63'd0, valid}, 64'd0);
    #2;

    // Write then immediate read of the same bank: read dropped.
    k = obs.size();
    drive(1'b1, 2'b10, 0, 5, 64'hAAAA_5555_1234_0005);
    drive(1'b1, 2'b01, 0, 5, 64'd0);
    idle(6);
    chk("b2b_viol", {48'd0, viol}, 64'd1);
    chk("b2b_no_rsp", 64'(obs.size()), 64'(k));

    // Write at phase 0, read 3 cycles later at phase 1.
    if (cyc % 2 != 0) idle(1);
    n = cyc;
    drive(1'b1, 2'b10, 1, 12'h003, 64'h00000011_00000022);
    idle(2);
    k = obs.size();
    drive(1'b1, 2'b01, 1, 12'h003, 64'd0);
    idle(6);
    chk("wr_rd_cnt", 64'(obs.size()), 64'(k + 1));
    if (obs.size() == k + 1) begin
      chk("wr_rd_cyc", 64'(obs[k].cyc), 64'(n + 3 + 4));
      chk("wr_rd_data", obs[k].data, 64'h00000011_00000022);
      chk("wr_rd_chan", {63'd0, obs[k].chan}, 64'd1);
    end

    // Prefill every entry; banks rotate so nothing is dropped.
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, 2'b10, i % 4, 12'h0A0 | (i / 4), pf((i % 4) * 16 + i / 4));
    end
    idle(3);

    // Back-to-back reads to four banks.
    if (cyc % 2 != 0) idle(1);
    n = cyc;
    k = obs.size();
    for (int i = 0; i < 4; i++) drive(1'b1, 2'b01, i, i + 1, 64'd0);
    idle(6);
    chk("b4_cnt", 64'(obs.size()), 64'(k + 4));
    if (obs.size() == k + 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("b4_cyc", 64'(obs[k+i].cyc), 64'(n + 4 + i));
        chk("b4_chan", {63'd0, obs[k+i].chan}, 64'(i % 2));
        chk("b4_data", obs[k+i].data, pf(i * 16 + i + 1));
      end
    end

    // Refresh blocks the next 8 cycles of reads.
    idle(10);
    v0 = int'(viol);
    k  = obs.size();
    n  = cyc;
    drive(1'b1, 2'b11, 0, 0, 64'd0);
    for (int i = 0; i < 8; i++) drive(1'b1, 2'b01, $urandom_range(0, 3), $urandom, 64'd0);
    drive(1'b1, 2'b01, 2, 5, 64'd0);
    idle(6);
    chk("ref_viol", 64'(int'(viol) - v0), 64'd8);
    chk("ref_cnt", 64'(obs.size()), 64'(k + 1));
    if (obs.size() == k + 1) begin
      chk("ref_cyc", 64'(obs[k].cyc), 64'(n + 9 + 4));
      chk("ref_data", obs[k].data, pf(2 * 16 + 5));
    end

    // Write code with cs low is a no-op.
    idle(4);
    v0 = int'(viol);
    drive(1'b0, 2'b10, 3, 7, {$urandom, $urandom});
    idle(3);
    k = obs.size();
    drive(1'b1, 2'b01, 3, 7, 64'd0);
    idle(6);
    chk("cs0_viol", {48'd0, viol}, 64'(v0));
    chk("cs0_cnt", 64'(obs.size()), 64'(k + 1));
    if (obs.size() == k + 1) chk("cs0_data", obs[k].data, pf(3 * 16 + 7));

    // Reset pulse discards an in-flight read; storage survives.
    idle(4);
    drive(1'b1, 2'b10, 1, 3, 64'hDEADBEEF_01234567);
    idle(3);
    k = obs.size();
    drive(1'b1, 2'b01, 1, 3, 64'd0);
    idle(1);
    reset_poweron = 1'b0;
    cs = 1'b0;
    @(posedge clk);
    #2 reset_poweron = 1'b1;
    idle(8);
    chk("rst_mid_cnt", 64'(obs.size()), 64'(k));
    chk("rst_mid_viol", {48'd0, viol}, 64'd0);
    drive(1'b1, 2'b01, 1, 3, 64'd0);
    idle(6);
    chk("rst_keep_cnt", 64'(obs.size()), 64'(k + 1));
    if (obs.size() == k + 1) chk("rst_keep_data", obs[k].data, 64'hDEADBEEF_01234567);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [1:0] code;
      r = $urandom_range(0, 99);
      code = (r < 45) ? 2'b01 : (r < 85) ? 2'b10 : (r < 90) ? 2'b11 : 2'b00;
      drive($urandom_range(0, 9) != 0, code, $urandom_range(0, 3), $urandom,
            {$urandom, $urandom});
    end
    idle(8);
    chk("drain", 64'(pend.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
